// File: rtl/mul_issue_ctrl.sv
// Request sequencer in front of the 16-bit multiplier: buffers requests in a small FIFO,
// issues them one at a time, and returns products (or a watchdog error) in order.
module mul_issue_ctrl #(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned TIMEOUT = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [15:0]      req_a,
    input  logic [15:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             mul_start,
    output logic [15:0]      mul_a,
    output logic [15:0]      mul_b,
    input  logic             mul_done,
    input  logic [15:0]      mul_result,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [15:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_err,
    output logic             busy
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [7:0]       WD_LIMIT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    state_e state_q, state_d;

    logic [15:0]      fifo_a_q   [DEPTH];
    logic [15:0]      fifo_b_q   [DEPTH];
    logic [TAG_W-1:0] fifo_tag_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;

    logic [15:0]      mul_a_q, mul_b_q;
    logic [TAG_W-1:0] tag_q;
    logic [7:0]       wd_q, wd_d;
    logic [15:0]      resp_data_q, resp_data_d;
    logic             resp_err_q, resp_err_d;

    logic push, pop, fifo_empty;

    assign fifo_empty = (count_q == '0);
    // Ready is driven only from registered count, so a same-cycle pop never re-opens it.
    assign req_ready  = reset && (count_q != FULL_CNT);
    assign push       = req_valid && req_ready;

    // FIFO storage and pointers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_a_q[i]   <= '0;
                fifo_b_q[i]   <= '0;
                fifo_tag_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_a_q[wr_ptr_q]   <= req_a;
                fifo_b_q[wr_ptr_q]   <= req_b;
                fifo_tag_q[wr_ptr_q] <= req_tag;
                wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Operand and tag registers change only at the pop edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_a_q <= '0;
            mul_b_q <= '0;
            tag_q   <= '0;
        end else if (pop) begin
            mul_a_q <= fifo_a_q[rd_ptr_q];
            mul_b_q <= fifo_b_q[rd_ptr_q];
            tag_q   <= fifo_tag_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            wd_q        <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wd_q        <= wd_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wd_d        = wd_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        pop         = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                wd_d    = '0;
                state_d = StWait;
            end
            StWait: begin
                // A done pulse in the timeout cycle still delivers the product.
                if (mul_done) begin
                    resp_data_d = mul_result;
                    resp_err_d  = 1'b0;
                    state_d     = StResp;
                end else if (wd_q == WD_LIMIT) begin
                    resp_data_d = '0;
                    resp_err_d  = 1'b1;
                    state_d     = StResp;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign mul_start  = (state_q == StIssue);
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign resp_valid = (state_q == StResp);
    assign resp_data  = resp_data_q;
    assign resp_tag   = tag_q;
    assign resp_err   = resp_err_q;
    assign busy       = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl with a behavioural fixed-latency multiplier.
module tb_mul_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_a = '0, req_b = '0;
    logic [3:0]  req_tag = '0;
    logic        mul_start;
    logic [15:0] mul_a, mul_b;
    wire         mul_done;
    logic [15:0] mul_result;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [15:0] resp_data;
    logic [3:0]  resp_tag;
    logic        resp_err;
    logic        busy;

    logic        m_done, m_busy, stray_done = 1'b0, mul_en = 1'b1;
    logic [7:0]  m_cnt, lat = 8'd3;
    logic [15:0] m_res;
    int          n_checks = 0, n_fail = 0, n_starts = 0, n_overlap = 0;

    assign mul_done = m_done | stray_done;

    always #5 clk = ~clk;

    mul_issue_ctrl #(.DEPTH(2), .TAG_W(4), .TIMEOUT(31)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_done   (mul_done),
        .mul_result (mul_result),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    // Multiplier model: product appears `lat` cycles after start; silent when mul_en is low.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy     <= 1'b0;
            m_done     <= 1'b0;
            m_cnt      <= '0;
            m_res      <= '0;
            mul_result <= '0;
        end else begin
            m_done <= 1'b0;
            if (mul_start) begin
                if (m_busy) n_overlap <= n_overlap + 1;
                m_busy <= mul_en;
                m_cnt  <= lat;
                m_res  <= mul_a * mul_b;
            end else if (m_busy) begin
                if (m_cnt <= 8'd1) begin
                    m_done     <= 1'b1;
                    mul_result <= m_res;
                    m_busy     <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 8'd1;
                end
            end
        end
    end

    always @(posedge clk) if (mul_start) n_starts <= n_starts + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag);
        int t = 0;
        while (!req_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) check("send_ready_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic get_resp(input string name, input logic [15:0] d, input logic [3:0] tg,
                            input logic e);
        int t = 0;
        resp_ready = 1'b1;
        while (!resp_valid && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) check({name, ".valid_timeout"}, 32'(resp_valid), 32'd1);
        check({name, ".data"}, 32'(resp_data), 32'(d));
        check({name, ".tag"}, 32'(resp_tag), 32'(tg));
        check({name, ".err"}, 32'(resp_err), 32'(e));
        @(negedge clk);
    endtask

    initial begin
        int s0, k, seen;
        logic stable, saw_full;
        logic [15:0] hd;
        logic [3:0] ht;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst.req_ready", 32'(req_ready), 32'd0);
        check("rst.mul_start", 32'(mul_start), 32'd0);
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.mul_a", 32'(mul_a), 32'd0);
        reset = 1'b1;
        #1;
        check("rst.req_ready_rel", 32'(req_ready), 32'd1);
        check("rst.resp_data", 32'(resp_data), 32'd0);
        check("rst.resp_tag", 32'(resp_tag), 32'd0);
        check("rst.resp_err", 32'(resp_err), 32'd0);
        @(negedge clk);

        // Single request with cycle timing
        s0 = n_starts;
        send(16'd3, 16'd5, 4'd7);
        check("t1.start_e0", 32'(mul_start), 32'd0);
        check("t1.busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("t1.start_e1", 32'(mul_start), 32'd1);
        check("t1.mul_a", 32'(mul_a), 32'd3);
        check("t1.mul_b", 32'(mul_b), 32'd5);
        @(negedge clk);
        check("t1.start_e2", 32'(mul_start), 32'd0);
        get_resp("t1", 16'd15, 4'd7, 1'b0);
        check("t1.busy_after", 32'(busy), 32'd0);
        check("t1.starts", 32'(n_starts - s0), 32'd1);

        // Operand patterns
        send(16'hFFFE, 16'h0003, 4'd2);
        get_resp("t2a", 16'hFFFA, 4'd2, 1'b0);
        send(16'h00FF, 16'h0101, 4'd4);
        get_resp("t2b", 16'hFFFF, 4'd4, 1'b0);
        send(16'h1234, 16'h0000, 4'd6);
        get_resp("t2c", 16'h0000, 4'd6, 1'b0);

        // Four back-to-back requests
        s0 = n_starts;
        saw_full = 1'b0;
        fork
            begin
                send(16'd2, 16'd3, 4'd1);
                send(16'd4, 16'd5, 4'd2);
                send(16'd100, 16'd100, 4'd3);
                if (!req_ready) saw_full = 1'b1;
                send(16'h0100, 16'h0100, 4'd4);
            end
            begin
                get_resp("t3.r1", 16'd6, 4'd1, 1'b0);
                get_resp("t3.r2", 16'd20, 4'd2, 1'b0);
                get_resp("t3.r3", 16'h2710, 4'd3, 1'b0);
                get_resp("t3.r4", 16'h0000, 4'd4, 1'b0);
            end
        join
        check("t3.saw_full", 32'(saw_full), 32'd1);
        check("t3.starts", 32'(n_starts - s0), 32'd4);
        check("t3.overlap", 32'(n_overlap), 32'd0);

        // Backpressure on the response port
        repeat (2) @(negedge clk);
        resp_ready = 1'b0;
        send(16'd11, 16'd3, 4'd5);
        k = 0;
        while (!resp_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        s0 = n_starts;
        hd = resp_data;
        ht = resp_tag;
        send(16'd2, 16'd2, 4'd6);
        send(16'd7, 16'd7, 4'd8);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!resp_valid || resp_data !== hd || resp_tag !== ht) stable = 1'b0;
        end
        check("t4.stable", 32'(stable), 32'd1);
        check("t4.data_held", 32'(resp_data), 32'd33);
        check("t4.no_start", 32'(n_starts - s0), 32'd0);
        check("t4.req_ready", 32'(req_ready), 32'd0);
        get_resp("t4.r1", 16'd33, 4'd5, 1'b0);
        get_resp("t4.r2", 16'd4, 4'd6, 1'b0);
        get_resp("t4.r3", 16'd49, 4'd8, 1'b0);

        // Watchdog timeout
        repeat (2) @(negedge clk);
        mul_en = 1'b0;
        resp_ready = 1'b0;
        send(16'd6, 16'd7, 4'd9);
        k = 0;
        while (!mul_start && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t5.start_seen", 32'(mul_start), 32'd1);
        k = 0;
        while (!resp_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("t5.edges", 32'(k - 1), 32'd32);
        check("t5.err", 32'(resp_err), 32'd1);
        check("t5.data", 32'(resp_data), 32'd0);
        check("t5.tag", 32'(resp_tag), 32'd9);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        check("t5.stray_data", 32'(resp_data), 32'd0);
        check("t5.stray_err", 32'(resp_err), 32'd1);
        get_resp("t5.r", 16'd0, 4'd9, 1'b1);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        repeat (3) @(negedge clk);
        check("t5.idle_valid", 32'(resp_valid), 32'd0);
        check("t5.idle_busy", 32'(busy), 32'd0);
        mul_en = 1'b1;
        send(16'd12, 16'd12, 4'd3);
        get_resp("t5.next", 16'd144, 4'd3, 1'b0);

        // Reset during WAIT with two requests queued
        lat = 8'd20;
        send(16'd1, 16'd1, 4'd1);
        send(16'd2, 16'd2, 4'd2);
        send(16'd3, 16'd3, 4'd3);
        repeat (3) @(negedge clk);
        check("t6.full", 32'(req_ready), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("t6.mul_start", 32'(mul_start), 32'd0);
        check("t6.busy", 32'(busy), 32'd0);
        check("t6.req_ready", 32'(req_ready), 32'd0);
        check("t6.mul_a", 32'(mul_a), 32'd0);
        check("t6.resp_tag", 32'(resp_tag), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        lat = 8'd3;
        s0 = n_starts;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_valid || mul_start) seen++;
        end
        check("t6.no_resp", 32'(seen), 32'd0);
        check("t6.no_start", 32'(n_starts - s0), 32'd0);
        send(16'd9, 16'd9, 4'd10);
        get_resp("t6.fresh", 16'd81, 4'd10, 1'b0);
        check("t6.starts", 32'(n_starts - s0), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_issue_ctrl.md
# mul_issue_ctrl

Request sequencer that sits directly upstream of the 16-bit Karatsuba multiplier. It accepts multiply requests from the execute stage over a valid/ready handshake and buffers them in a small FIFO. It issues each request to the multiplier as a one-cycle start pulse with stable operands, waits for the multiplier's done pulse, and returns the product with its destination tag over a second valid/ready handshake. A watchdog converts a hung multiplier into an error response.

## Interface
- DEPTH, 2: request FIFO entries (power of two, ≥2)
- TAG_W, 4: width of destination-register tag
- TIMEOUT, 31: max WAIT cycles before error response (≤255)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low (low = reset); top level drives multiplier reset with its inverse
- req_valid  input  1  request present
- req_ready  output  1  FIFO can accept (= not full)
- req_a, req_b  input  16 each  operands
- req_tag  input  TAG_W  destination tag
- mul_start  output  1  one-cycle start pulse to multiplier
- mul_a, mul_b  output  16 each  operands, held stable from ISSUE until next ISSUE
- mul_done  input  1  multiplier done pulse
- mul_result  input  16  multiplier product (low 16 bits)
- resp_valid  output  1  response present
- resp_ready  input  1  consumer accepts
- resp_data  output  16  product
- resp_tag  output  TAG_W  tag of the request
- resp_err  output  1  timeout occurred, resp_data = 0
- busy  output  1  FSM not IDLE or FIFO non-empty

## Operation
- Push on req_valid && req_ready. req_ready = (count != DEPTH); a pop in the same cycle does not re-open a full FIFO.
- FSM states:
  - IDLE: if FIFO non-empty, pop head into mul_a/mul_b/tag registers → ISSUE.
  - ISSUE: mul_start = 1 for exactly this cycle; clear watchdog → WAIT.
  - WAIT: on mul_done, capture mul_result into resp_data, resp_err = 0 → RESP. Otherwise increment watchdog. When watchdog == TIMEOUT without done: resp_data = 0, resp_err = 1 → RESP. Done and timeout in the same cycle: done wins.
  - RESP: resp_valid = 1; resp_data/tag/err stable until resp_ready → IDLE.
- One request in flight at a time. Responses return in request order.
- mul_done outside WAIT is ignored; a done pulse arriving after a timeout is discarded.
- Arithmetic: no processing. resp_data = mul_result bit-for-bit (signed and unsigned low-16 identical).
- Reset values: req_ready 1 once reset is released (0 while low), mul_start 0, mul_a/mul_b 0, resp_valid 0, resp_data 0, resp_tag 0, resp_err 0, busy 0, FIFO empty, state IDLE, watchdog 0.
- Reset mid-operation: FIFO contents and the in-flight request are dropped, with no response. mul_start goes low immediately (async).

## Timing
- Request accepted at edge E0, FSM IDLE, FIFO empty: pop at E1 and mul_start high in cycle E1–E2. State is WAIT from E2.
- If mul_done is high in the cycle ending at edge Ed, resp_valid is high from Ed. Response handshake completes at the first edge with resp_ready = 1. IDLE is reached at that edge, and the next pop follows one edge later.
- Overhead beyond multiplier latency: 2 cycles into the multiplier, 0 cycles back. Minimum 1 idle cycle between responses.
- Timeout: resp_valid is asserted TIMEOUT+1 edges after entering WAIT.
- mul_a/mul_b change only at the pop edge. They never change while WAIT or RESP is active.
- Combinational paths: none from inputs to outputs. req_ready depends only on count.

## Test plan
- Single request a=3, b=5, tag=7: one mul_start pulse; response resp_data=15, resp_tag=7, resp_err=0; busy falls the cycle after the handshake.
- a=0xFFFE, b=0x0003, tag=2 → resp_data=0xFFFA. a=0x00FF, b=0x0101 → 0xFFFF. a=0x1234, b=0 → 0.
- Four back-to-back requests with resp_ready=1 (DEPTH=2): req_ready drops low while FIFO is full. All four responses arrive in order with correct tags. mul_start pulses exactly 4 times, never while WAIT is active.
- Hold resp_ready=0 for 10 cycles during RESP: resp_valid, resp_data and resp_tag are stable. No new mul_start. FIFO fills and req_ready=0.
- mul_done tied low: resp_err=1, resp_data=0 exactly TIMEOUT+1 edges after WAIT entry. A later stray mul_done is ignored, and the next request proceeds normally.
- Assert reset low during WAIT with 2 queued requests: all outputs take reset values asynchronously. After release, no response for dropped requests. A fresh request 9×9 returns 81.
